// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake bundle between the PC sequencer (master) and the
// instruction memory / decode / execute side (slave).
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic            instr_valid;
    logic            ex_valid;
    logic [2:0]      branch;
    logic            zero;
    logic            less;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] pc;
    logic            retire;
    logic            misalign;

    modport master (
        output imem_req, imem_addr, instr_valid, pc, retire, misalign,
        input  imem_ack, ex_valid, branch, zero, less, imm, rs1
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, pc, retire, misalign,
        output imem_ack, ex_valid, branch, zero, less, imm, rs1
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: BOOT -> FETCH (req/ack) -> EXEC (wait ex_valid,
// resolve next PC from branch code and ALU flags) -> FETCH.
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.master bus
);
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic            instr_valid_r;
    logic            retire_r;
    logic            misalign_r;

    logic            taken_s;
    logic            trap_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] next_pc_s;

    // Branch resolution: taken decision, target, and misalignment redirect.
    always_comb begin
        taken_s   = 1'b0;
        target_s  = pc_r + bus.imm;
        next_pc_s = pc_r + PC_STEP;
        case (bus.branch)
            3'b000:  taken_s = 1'b0;
            3'b001:  taken_s = 1'b1;
            3'b010:  taken_s = 1'b1;
            3'b011:  taken_s = 1'b0;
            3'b100:  taken_s = bus.zero;
            3'b101:  taken_s = ~bus.zero;
            3'b110:  taken_s = bus.less;
            3'b111:  taken_s = ~bus.less;
            default: taken_s = 1'b0;
        endcase
        if (bus.branch == 3'b010) begin
            target_s = (bus.rs1 + bus.imm) & JALR_MASK;
        end else begin
            target_s = pc_r + bus.imm;
        end
        // Only a taken target can trap; not-taken branches ignore their target.
        trap_s = taken_s & target_s[1];
        if (trap_s) begin
            next_pc_s = TRAP_PC;
        end else if (taken_s) begin
            next_pc_s = target_s;
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
    end

    // Sequencer FSM with registered pc and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            instr_valid_r <= 1'b0;
            retire_r      <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            instr_valid_r <= 1'b0;
            retire_r      <= 1'b0;
            case (state_r)
                BOOT: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        state_r       <= EXEC;
                        instr_valid_r <= 1'b1;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                EXEC: begin
                    if (bus.ex_valid) begin
                        state_r    <= FETCH;
                        pc_r       <= next_pc_s;
                        retire_r   <= 1'b1;
                        misalign_r <= misalign_r | trap_s;
                    end else begin
                        state_r <= EXEC;
                    end
                end
                default: begin
                    state_r <= BOOT;
                end
            endcase
        end
    end

    // Request is decoded from state so it falls together with async reset.
    assign bus.imem_req    = (state_r == FETCH);
    assign bus.imem_addr   = pc_r;
    assign bus.pc          = pc_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.retire      = retire_r;
    assign bus.misalign    = misalign_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// reset/handshake sequences, and randomized instructions against a reference model.
module tb_pc_sequencer;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] cur_pc;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .TRAP_PC(TRAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  br;
        logic        z;
        logic        l;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[18];

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural next-PC rule: which codes take, where they go, when they trap.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [2:0] br,
                                             input logic z, input logic l,
                                             input logic [31:0] imm, input logic [31:0] rs1,
                                             output logic trap);
        logic take;
        logic [31:0] dest;
        int code;
        code = int'(br);
        take = (code == 1) || (code == 2) || (code == 4 && z) || (code == 5 && !z)
            || (code == 6 && l) || (code == 7 && !l);
        if (code == 2) dest = ((rs1 + imm) / 32'd2) * 32'd2;
        else           dest = pc + imm;
        trap = take && ((dest % 32'd4) >= 32'd2);
        if (trap)      return TRAP;
        else if (take) return dest;
        else           return pc + 32'd4;
    endfunction

    task automatic idle_inputs;
        bus.imem_ack = 1'b0;
        bus.ex_valid = 1'b0;
        bus.branch   = 3'b000;
        bus.zero     = 1'b0;
        bus.less     = 1'b0;
        bus.imm      = 32'h0;
        bus.rs1      = 32'h0;
    endtask

    task automatic release_reset;
        rst = 1'b0;
        chk("boot_req", {31'h0, bus.imem_req}, 32'd0);
        tick;
        chk("post_boot_req", {31'h0, bus.imem_req}, 32'd1);
        chk("post_boot_addr", bus.imem_addr, 32'h0);
        cur_pc = 32'h0;
    endtask

    task automatic do_reset;
        idle_inputs;
        rst = 1'b1;
        tick;
        tick;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_req", {31'h0, bus.imem_req}, 32'd0);
        chk("rst_iv", {31'h0, bus.instr_valid}, 32'd0);
        chk("rst_retire", {31'h0, bus.retire}, 32'd0);
        chk("rst_mis", {31'h0, bus.misalign}, 32'd0);
        release_reset;
    endtask

    // One full instruction starting at a negedge in FETCH; ends at a negedge in FETCH.
    task automatic run_instr(input logic [2:0] br, input logic z, input logic l,
                             input logic [31:0] imm, input logic [31:0] rs1,
                             input int ack_d, input int ex_d,
                             input logic [31:0] exp_pc, input logic exp_mis);
        chk("fetch_req", {31'h0, bus.imem_req}, 32'd1);
        chk("fetch_addr", bus.imem_addr, cur_pc);
        for (int d = 0; d < ack_d; d++) begin
            bus.imem_ack = 1'b0;
            bus.ex_valid = 1'b1;
            bus.branch   = 3'b001;
            bus.imm      = 32'h0000_0040;
            tick;
            chk("ackwait_req", {31'h0, bus.imem_req}, 32'd1);
            chk("ackwait_addr", bus.imem_addr, cur_pc);
            chk("ackwait_iv", {31'h0, bus.instr_valid}, 32'd0);
            chk("ackwait_pc", bus.pc, cur_pc);
        end
        bus.ex_valid = 1'b0;
        bus.imem_ack = 1'b1;
        tick;
        bus.imem_ack = 1'b0;
        chk("exec_iv", {31'h0, bus.instr_valid}, 32'd1);
        chk("exec_req", {31'h0, bus.imem_req}, 32'd0);
        chk("exec_retire", {31'h0, bus.retire}, 32'd0);
        for (int d = 0; d < ex_d; d++) begin
            bus.imem_ack = 1'b1;
            bus.ex_valid = 1'b0;
            tick;
            chk("exwait_iv", {31'h0, bus.instr_valid}, 32'd0);
            chk("exwait_retire", {31'h0, bus.retire}, 32'd0);
            chk("exwait_req", {31'h0, bus.imem_req}, 32'd0);
        end
        bus.imem_ack = 1'b0;
        bus.branch   = br;
        bus.zero     = z;
        bus.less     = l;
        bus.imm      = imm;
        bus.rs1      = rs1;
        bus.ex_valid = 1'b1;
        tick;
        bus.ex_valid = 1'b0;
        chk("retire", {31'h0, bus.retire}, 32'd1);
        chk("next_pc", bus.pc, exp_pc);
        chk("misalign", {31'h0, bus.misalign}, {31'h0, exp_mis});
        chk("refetch_req", {31'h0, bus.imem_req}, 32'd1);
        chk("refetch_addr", bus.imem_addr, exp_pc);
        cur_pc = exp_pc;
    endtask

    initial begin
        logic [2:0]  r_br;
        logic        r_z;
        logic        r_l;
        logic        r_trap;
        logic        mis_m;
        logic [31:0] r_imm;
        logic [31:0] r_rs1;
        logic [31:0] r_exp;

        checks = 0;
        errors = 0;
        cur_pc = 32'h0;
        rst    = 1'b1;
        idle_inputs;

        tbl[0]  = '{3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0004, 1'b0};
        tbl[1]  = '{3'b000, 1'b1, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_0008, 1'b0};
        tbl[2]  = '{3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_000C, 1'b0};
        tbl[3]  = '{3'b001, 1'b0, 1'b0, 32'h0000_0034, 32'h0,         32'h0000_0040, 1'b0};
        tbl[4]  = '{3'b100, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0060, 1'b0};
        tbl[5]  = '{3'b001, 1'b0, 1'b0, 32'hFFFF_FFE0, 32'h0,         32'h0000_0040, 1'b0};
        tbl[6]  = '{3'b100, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0044, 1'b0};
        tbl[7]  = '{3'b111, 1'b0, 1'b0, 32'h0000_001C, 32'h0,         32'h0000_0060, 1'b0};
        tbl[8]  = '{3'b111, 1'b0, 1'b1, 32'h0000_001C, 32'h0,         32'h0000_0064, 1'b0};
        tbl[9]  = '{3'b110, 1'b0, 1'b1, 32'h0000_0004, 32'h0,         32'h0000_0068, 1'b0};
        tbl[10] = '{3'b101, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_006C, 1'b0};
        tbl[11] = '{3'b011, 1'b0, 1'b0, 32'h0000_0006, 32'h0,         32'h0000_0070, 1'b0};
        tbl[12] = '{3'b010, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_1001, 32'h0000_1010, 1'b0};
        tbl[13] = '{3'b100, 1'b0, 1'b0, 32'h0000_0002, 32'h0,         32'h0000_1014, 1'b0};
        tbl[14] = '{3'b001, 1'b0, 1'b0, 32'h0000_0006, 32'h0,         TRAP,          1'b1};
        tbl[15] = '{3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0104, 1'b1};
        tbl[16] = '{3'b010, 1'b0, 1'b0, 32'h0000_000C, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 1'b1};
        tbl[17] = '{3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1};

        do_reset;
        for (int i = 0; i < 18; i++) begin
            run_instr(tbl[i].br, tbl[i].z, tbl[i].l, tbl[i].imm, tbl[i].rs1,
                      0, 0, tbl[i].exp_pc, tbl[i].exp_mis);
        end

        // Slow memory and slow execute; ex_valid during FETCH must be ignored.
        do_reset;
        run_instr(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 3, 2, 32'h0000_0004, 1'b0);
        run_instr(3'b001, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 2, 1, 32'h0000_0014, 1'b0);

        // Reset mid-EXEC with ex_valid high: abort, no retire, restart at BOOT.
        idle_inputs;
        bus.imem_ack = 1'b1;
        tick;
        bus.imem_ack = 1'b0;
        chk("abort_exec_iv", {31'h0, bus.instr_valid}, 32'd1);
        bus.ex_valid = 1'b1;
        bus.branch   = 3'b001;
        bus.imm      = 32'h0000_0040;
        #1 rst = 1'b1;
        #1;
        chk("abort_pc", bus.pc, 32'h0);
        chk("abort_req", {31'h0, bus.imem_req}, 32'd0);
        tick;
        chk("abort_retire", {31'h0, bus.retire}, 32'd0);
        chk("abort_pc_held", bus.pc, 32'h0);
        idle_inputs;
        release_reset;
        run_instr(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0000_0004, 1'b0);

        // Reset mid-FETCH drops the request asynchronously.
        #1 rst = 1'b1;
        #1;
        chk("fetch_abort_req", {31'h0, bus.imem_req}, 32'd0);
        @(negedge clk);
        release_reset;

        // Randomized instruction stream checked against the reference model.
        mis_m = 1'b0;
        for (int i = 0; i < 240; i++) begin
            if (i % 40 == 0) begin
                do_reset;
                mis_m = 1'b0;
            end
            r_br  = 3'($urandom_range(0, 7));
            r_z   = 1'($urandom_range(0, 1));
            r_l   = 1'($urandom_range(0, 1));
            r_imm = $urandom;
            r_rs1 = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                r_imm[1:0] = 2'b00;
                r_rs1[1:0] = 2'($urandom_range(0, 1));
            end
            r_exp = ref_next(cur_pc, r_br, r_z, r_l, r_imm, r_rs1, r_trap);
            mis_m = mis_m | r_trap;
            run_instr(r_br, r_z, r_l, r_imm, r_rs1,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_exp, mis_m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
